// File: rtl/reg_dst_pipe_if.sv
// ----------------------------------------------------------------------------
// reg_dst_pipe_if
//   Groups the ID-stage control/field inputs and the per-stage destination
//   outputs of reg_dst_pipe into one bundle. Clock and reset stay outside.
//
//   Parameters
//     BITS_REGS : register address width
//     STAGES    : number of tracked pipeline stages (stage 0 = EX)
//
//   Signals (direction as seen by the pipe, i.e. the slave side)
//     i_stall           in   hold all stages
//     i_flush           in   load a bubble into stage 0
//     i_valid           in   ID-stage instruction valid
//     i_ctl_reg_dst     in   00 rt, 01 rd, 10 link register, 11 none
//     i_ctl_reg_write   in   instruction writes the register file
//     i_rt/i_rd/i_rs    in   register fields of the ID instruction
//     o_mux_register_rd out  combinational selected destination
//     o_dst_flat        out  stage k destination at [k*BITS_REGS +: BITS_REGS]
//     o_we_flat         out  stage k effective write enable
//     o_rs_hit/o_rt_hit out  stage k writes i_rs / i_rt
//     o_wb_dst/o_wb_we  out  last stage destination and write enable
// ----------------------------------------------------------------------------
interface reg_dst_pipe_if #(
    parameter int BITS_REGS = 5,
    parameter int STAGES    = 3
);
    logic                          i_stall;
    logic                          i_flush;
    logic                          i_valid;
    logic [1:0]                    i_ctl_reg_dst;
    logic                          i_ctl_reg_write;
    logic [BITS_REGS-1:0]          i_rt;
    logic [BITS_REGS-1:0]          i_rd;
    logic [BITS_REGS-1:0]          i_rs;
    logic [BITS_REGS-1:0]          o_mux_register_rd;
    logic [STAGES*BITS_REGS-1:0]   o_dst_flat;
    logic [STAGES-1:0]             o_we_flat;
    logic [STAGES-1:0]             o_rs_hit;
    logic [STAGES-1:0]             o_rt_hit;
    logic [BITS_REGS-1:0]          o_wb_dst;
    logic                          o_wb_we;

    // Driver side: the ID stage / hazard unit that feeds and observes the pipe
    modport master (
        output i_stall, i_flush, i_valid, i_ctl_reg_dst, i_ctl_reg_write,
               i_rt, i_rd, i_rs,
        input  o_mux_register_rd, o_dst_flat, o_we_flat, o_rs_hit, o_rt_hit,
               o_wb_dst, o_wb_we
    );

    // Pipe side
    modport slave (
        input  i_stall, i_flush, i_valid, i_ctl_reg_dst, i_ctl_reg_write,
               i_rt, i_rd, i_rs,
        output o_mux_register_rd, o_dst_flat, o_we_flat, o_rs_hit, o_rt_hit,
               o_wb_dst, o_wb_we
    );
endinterface

// File: rtl/reg_dst_pipe.sv
// ----------------------------------------------------------------------------
// reg_dst_pipe
//   Selects the write-back destination register (rt, rd or link register),
//   qualifies it with the register-write control, and carries destination plus
//   write enable through STAGES pipeline registers (EX .. WB) with stall and
//   flush. Every stage destination is exported for hazard/forwarding logic,
//   together with per-stage match flags against the ID-stage rs/rt fields.
//
//   Parameters
//     BITS_REGS : register address width
//     STAGES    : stages tracked, stage 0 = EX, stage STAGES-1 = WB (>= 1)
//     RA_ADDR   : destination used for the link select (truncated)
//
//   Ports
//     i_clk   : clock, rising edge
//     i_rst_n : asynchronous active-low reset
//     bus     : reg_dst_pipe_if slave (controls, fields, stage outputs)
// ----------------------------------------------------------------------------
module reg_dst_pipe #(
    parameter int BITS_REGS = 5,
    parameter int STAGES    = 3,
    parameter int RA_ADDR   = 31
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    reg_dst_pipe_if.slave        bus
);

    localparam logic [BITS_REGS-1:0] W_RA = BITS_REGS'(RA_ADDR);

    logic [BITS_REGS-1:0]        r_dst [STAGES];
    logic [STAGES-1:0]           r_we;

    logic [BITS_REGS-1:0]        w_sel;
    logic                        w_we_in;
    logic [STAGES*BITS_REGS-1:0] w_dst_flat;
    logic [STAGES-1:0]           w_rs_hit;
    logic [STAGES-1:0]           w_rt_hit;

    // Destination mux. The "no destination" code yields register 0, which
    // also makes the register-0 test below reject it.
    always_comb begin
        w_sel = '0;
        case (bus.i_ctl_reg_dst)
            2'b00:   w_sel = bus.i_rt;
            2'b01:   w_sel = bus.i_rd;
            2'b10:   w_sel = W_RA;
            default: w_sel = '0;
        endcase
    end

    // A write to register 0 has no architectural effect, so it is never
    // tracked as a producer.
    assign w_we_in = bus.i_valid & bus.i_ctl_reg_write &
                     (bus.i_ctl_reg_dst != 2'b11) & (w_sel != '0);

    // Stage registers. Flush only bubbles stage 0; the older stages still
    // obey stall so an instruction already past EX is never lost or doubled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_dst[k] <= '0;
            end
            r_we <= '0;
        end else begin
            if (bus.i_flush) begin
                r_dst[0] <= '0;
                r_we[0]  <= 1'b0;
            end else if (!bus.i_stall) begin
                r_dst[0] <= w_sel;
                r_we[0]  <= w_we_in;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (!bus.i_stall) begin
                    r_dst[k] <= r_dst[k-1];
                    r_we[k]  <= r_we[k-1];
                end
            end
        end
    end

    // Flatten stage destinations and compare them against the ID fields.
    // Register 0 is never reported as a hazard source.
    always_comb begin
        w_dst_flat = '0;
        w_rs_hit   = '0;
        w_rt_hit   = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_dst_flat[k*BITS_REGS +: BITS_REGS] = r_dst[k];
            w_rs_hit[k] = r_we[k] & (r_dst[k] == bus.i_rs) & (bus.i_rs != '0);
            w_rt_hit[k] = r_we[k] & (r_dst[k] == bus.i_rt) & (bus.i_rt != '0);
        end
    end

    assign bus.o_mux_register_rd = w_sel;
    assign bus.o_dst_flat        = w_dst_flat;
    assign bus.o_we_flat         = r_we;
    assign bus.o_rs_hit          = w_rs_hit;
    assign bus.o_rt_hit          = w_rt_hit;
    assign bus.o_wb_dst          = r_dst[STAGES-1];
    assign bus.o_wb_we           = r_we[STAGES-1];

endmodule

// File: tb/tb_reg_dst_pipe.sv
// ----------------------------------------------------------------------------
// tb_reg_dst_pipe
//   Directed testbench for reg_dst_pipe (BITS_REGS=5, STAGES=3, RA_ADDR=31).
//   A behavioural model of the stage contents is compared against the DUT on
//   every falling edge, and hand-computed literal checks pin the model.
// ----------------------------------------------------------------------------
module tb_reg_dst_pipe;

    localparam int BITS   = 5;
    localparam int STAGES = 3;
    localparam int RA     = 31;

    logic clock;
    logic resetN;
    logic checkEn;

    int assertCount;
    int failCount;

    logic [BITS-1:0]   mDst [STAGES];
    logic [STAGES-1:0] mWe;

    reg_dst_pipe_if #(.BITS_REGS(BITS), .STAGES(STAGES)) dutIf ();

    reg_dst_pipe #(.BITS_REGS(BITS), .STAGES(STAGES), .RA_ADDR(RA)) dut (
        .i_clk   (clock),
        .i_rst_n (resetN),
        .bus     (dutIf.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Selection rule written straight from the destination table
    function automatic logic [BITS-1:0] expSel(input logic [1:0] s,
                                               input logic [BITS-1:0] rtV,
                                               input logic [BITS-1:0] rdV);
        logic [BITS-1:0] r;
        if (s == 2'd0)      r = rtV;
        else if (s == 2'd1) r = rdV;
        else if (s == 2'd2) r = BITS'(RA);
        else                r = '0;
        return r;
    endfunction

    // Model of the stage contents: what each stage must hold after an edge
    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int k = 0; k < STAGES; k++) mDst[k] <= '0;
            mWe <= '0;
        end else begin
            if (!dutIf.i_stall) begin
                for (int k = 1; k < STAGES; k++) begin
                    mDst[k] <= mDst[k-1];
                    mWe[k]  <= mWe[k-1];
                end
            end
            if (dutIf.i_flush) begin
                mDst[0] <= '0;
                mWe[0]  <= 1'b0;
            end else if (!dutIf.i_stall) begin
                mDst[0] <= expSel(dutIf.i_ctl_reg_dst, dutIf.i_rt, dutIf.i_rd);
                mWe[0]  <= dutIf.i_valid && dutIf.i_ctl_reg_write &&
                           (expSel(dutIf.i_ctl_reg_dst, dutIf.i_rt, dutIf.i_rd) != 0);
            end
        end
    end

    task automatic checkLit(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output against the model and the current inputs
    task automatic checkOutput(input string name);
        logic [STAGES*BITS-1:0] eFlat;
        logic [STAGES-1:0]      eRs;
        logic [STAGES-1:0]      eRt;
        for (int k = 0; k < STAGES; k++) begin
            eFlat[k*BITS +: BITS] = mDst[k];
            eRs[k] = mWe[k] && (mDst[k] == dutIf.i_rs) && (dutIf.i_rs != 0);
            eRt[k] = mWe[k] && (mDst[k] == dutIf.i_rt) && (dutIf.i_rt != 0);
        end
        checkLit({name, ".mux"}, 32'(dutIf.o_mux_register_rd),
                 32'(expSel(dutIf.i_ctl_reg_dst, dutIf.i_rt, dutIf.i_rd)));
        checkLit({name, ".dst"},   32'(dutIf.o_dst_flat), 32'(eFlat));
        checkLit({name, ".we"},    32'(dutIf.o_we_flat),  32'(mWe));
        checkLit({name, ".rsHit"}, 32'(dutIf.o_rs_hit),   32'(eRs));
        checkLit({name, ".rtHit"}, 32'(dutIf.o_rt_hit),   32'(eRt));
        checkLit({name, ".wbDst"}, 32'(dutIf.o_wb_dst),   32'(mDst[STAGES-1]));
        checkLit({name, ".wbWe"},  32'(dutIf.o_wb_we),    32'(mWe[STAGES-1]));
    endtask

    // Per-cycle comparison on the falling edge, away from the active edge
    always @(negedge clock) begin
        if (checkEn) checkOutput("model");
    end

    // Drive one ID-stage vector, let one rising edge pass, and return 2 ns
    // after the next falling edge with the inputs still applied.
    task automatic applyStimulus(input logic v, input logic [1:0] sel,
                                 input logic w, input logic [BITS-1:0] rtV,
                                 input logic [BITS-1:0] rdV,
                                 input logic [BITS-1:0] rsV,
                                 input logic st, input logic fl);
        dutIf.i_valid         = v;
        dutIf.i_ctl_reg_dst   = sel;
        dutIf.i_ctl_reg_write = w;
        dutIf.i_rt            = rtV;
        dutIf.i_rd            = rdV;
        dutIf.i_rs            = rsV;
        dutIf.i_stall         = st;
        dutIf.i_flush         = fl;
        @(negedge clock);
        #2;
    endtask

    task automatic bubble();
        applyStimulus(1'b0, 2'b00, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        checkEn     = 1'b0;
        resetN      = 1'b0;
        dutIf.i_valid = 1'b0; dutIf.i_ctl_reg_dst = 2'b00;
        dutIf.i_ctl_reg_write = 1'b0; dutIf.i_rt = '0; dutIf.i_rd = '0;
        dutIf.i_rs = '0; dutIf.i_stall = 1'b0; dutIf.i_flush = 1'b0;

        // Reset held for two cycles
        repeat (2) @(posedge clock);
        checkEn = 1'b1;
        @(negedge clock); #2;
        checkLit("rst.wbDst", 32'(dutIf.o_wb_dst), 0);
        checkLit("rst.wbWe",  32'(dutIf.o_wb_we), 0);
        checkLit("rst.we",    32'(dutIf.o_we_flat), 0);
        checkLit("rst.dst",   32'(dutIf.o_dst_flat), 0);
        resetN = 1'b1;

        // Destination select with rt=7, rd=12
        applyStimulus(1'b0, 2'b00, 1'b1, 5'd7, 5'd12, 5'd0, 1'b0, 1'b0);
        checkLit("sel.rt", 32'(dutIf.o_mux_register_rd), 7);
        applyStimulus(1'b0, 2'b01, 1'b1, 5'd7, 5'd12, 5'd0, 1'b0, 1'b0);
        checkLit("sel.rd", 32'(dutIf.o_mux_register_rd), 12);
        applyStimulus(1'b0, 2'b10, 1'b1, 5'd7, 5'd12, 5'd0, 1'b0, 1'b0);
        checkLit("sel.ra", 32'(dutIf.o_mux_register_rd), 31);
        applyStimulus(1'b0, 2'b11, 1'b1, 5'd7, 5'd12, 5'd0, 1'b0, 1'b0);
        checkLit("sel.none", 32'(dutIf.o_mux_register_rd), 0);

        // Latency: rd=12 then three bubbles
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd7, 5'd12, 5'd0, 1'b0, 1'b0);
        checkLit("lat.s0", 32'(dutIf.o_dst_flat[4:0]), 12);
        checkLit("lat.we0", 32'(dutIf.o_we_flat[0]), 1);
        bubble();
        checkLit("lat.s1", 32'(dutIf.o_dst_flat[9:5]), 12);
        bubble();
        checkLit("lat.wbDst", 32'(dutIf.o_wb_dst), 12);
        checkLit("lat.wbWe", 32'(dutIf.o_wb_we), 1);
        bubble();
        checkLit("lat.wbWeOff", 32'(dutIf.o_wb_we), 0);

        // Register 0 and disabled writes never become tracked producers
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b01, 1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
        checkLit("r0.wbWe1", 32'(dutIf.o_wb_we), 0);
        checkLit("r0.rsHit1", 32'(dutIf.o_rs_hit), 0);
        bubble();
        checkLit("r0.wbWe2", 32'(dutIf.o_wb_we), 0);
        checkLit("r0.wbDst2", 32'(dutIf.o_wb_dst), 5);
        bubble();
        checkLit("r0.wbWe3", 32'(dutIf.o_wb_we), 0);
        checkLit("r0.rsHit3", 32'(dutIf.o_rs_hit), 0);

        // Stall and flush: load 3, 4, 5
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd0, 5'd4, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
        checkLit("load.dst", 32'(dutIf.o_dst_flat), {17'd0, 5'd3, 5'd4, 5'd5});
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd0, 5'd9, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd0, 5'd9, 5'd0, 1'b1, 1'b0);
        checkLit("stall.dst", 32'(dutIf.o_dst_flat), {17'd0, 5'd3, 5'd4, 5'd5});
        checkLit("stall.we", 32'(dutIf.o_we_flat), 7);
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd0, 5'd9, 5'd0, 1'b1, 1'b1);
        checkLit("stflush.dst", 32'(dutIf.o_dst_flat), {17'd0, 5'd3, 5'd4, 5'd0});
        checkLit("stflush.we", 32'(dutIf.o_we_flat), 3'b110);
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 1'b1);
        checkLit("flush.dst", 32'(dutIf.o_dst_flat), {17'd0, 5'd4, 5'd0, 5'd0});
        checkLit("flush.we", 32'(dutIf.o_we_flat), 3'b100);

        // Hazard hits: stages {9, 9, 2}, rs=9 rt=2
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 5'd2, 5'd0, 5'd9, 1'b1, 1'b0);
        checkLit("hit.rs", 32'(dutIf.o_rs_hit), 3'b011);
        checkLit("hit.rt", 32'(dutIf.o_rt_hit), 3'b100);
        // Same destinations but stage 1 not writing
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd0, 5'd2, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b0, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b1, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'b00, 1'b0, 5'd2, 5'd0, 5'd9, 1'b1, 1'b0);
        checkLit("hitClr.rs", 32'(dutIf.o_rs_hit), 3'b001);
        checkLit("hitClr.rt", 32'(dutIf.o_rt_hit), 3'b100);

        // Async reset between edges with the pipeline full
        resetN = 1'b0;
        #1;
        checkLit("arst.we",  32'(dutIf.o_we_flat), 0);
        checkLit("arst.dst", 32'(dutIf.o_dst_flat), 0);
        checkLit("arst.rs",  32'(dutIf.o_rs_hit), 0);
        checkLit("arst.rt",  32'(dutIf.o_rt_hit), 0);
        @(negedge clock); #2;
        resetN = 1'b1;

        // Link and rt selections after reset
        applyStimulus(1'b1, 2'b10, 1'b1, 5'd6, 5'd8, 5'd31, 1'b0, 1'b0);
        checkLit("link.rsHit", 32'(dutIf.o_rs_hit), 3'b001);
        applyStimulus(1'b1, 2'b00, 1'b1, 5'd6, 5'd8, 5'd31, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b11, 1'b1, 5'd6, 5'd8, 5'd6, 1'b0, 1'b0);
        checkLit("link.wbDst", 32'(dutIf.o_wb_dst), 31);
        checkLit("link.rsHit6", 32'(dutIf.o_rs_hit), 3'b010);
        bubble();
        bubble();
        checkLit("none.wbWe", 32'(dutIf.o_wb_we), 0);

        checkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/reg_dst_pipe.md
Name: reg_dst_pipe

Overview:
- Parametrised successor to the rt/rd destination mux.
- Selects the write-back destination register from rt, rd or the link register, gated by the register-write control.
- Carries the selected destination and its write enable through STAGES pipeline registers (EX/MEM/WB), with stall and flush control.
- Exposes each stage's destination to the hazard/forwarding logic, plus per-stage match flags against the ID-stage rs/rt.

Parameters:
BITS_REGS, 5, register address width
STAGES, 3, number of pipeline stages tracked (stage 0 = EX, stage STAGES-1 = WB); minimum 1
RA_ADDR, 31, register index used as destination when the link select is chosen

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_stall  input  1  1 = hold all stages
i_flush  input  1  1 = load a bubble into stage 0
i_valid  input  1  ID-stage instruction valid
i_ctl_reg_dst  input  2  00 = rt, 01 = rd, 10 = RA_ADDR, 11 = no destination
i_ctl_reg_write  input  1  instruction writes the register file
i_rt  input  BITS_REGS  rt field of the ID instruction
i_rd  input  BITS_REGS  rd field of the ID instruction
i_rs  input  BITS_REGS  rs field of the ID instruction, used for hazard compare
o_mux_register_rd  output  BITS_REGS  combinational selected destination (11 gives 0)
o_dst_flat  output  STAGES*BITS_REGS  stage k destination at bits [k*BITS_REGS +: BITS_REGS]
o_we_flat  output  STAGES  stage k effective write enable
o_rs_hit  output  STAGES  stage k writes i_rs
o_rt_hit  output  STAGES  stage k writes i_rt
o_wb_dst  output  BITS_REGS  destination of stage STAGES-1
o_wb_we  output  1  write enable of stage STAGES-1

Behaviour:
- Reset (i_rst_n low, asynchronous, any time): all stage destinations = 0 and all write enables = 0, hence o_wb_dst = 0 and o_wb_we = 0. Reset mid-operation discards all in-flight entries. Operation resumes on the first rising edge after release.
- Selection is combinational: rt / rd / RA_ADDR / 0 per i_ctl_reg_dst.
- Effective enable:
  - we_in = i_valid & i_ctl_reg_write & (sel != 11) & (o_mux_register_rd != 0).
  - A write to register 0 is never tracked.
  - An entry with we_in = 0 still stores its destination field, which is don't-care for hits.
- Per rising edge, priority highest first:
  1. i_flush = 1: stage 0 <= bubble (dst 0, we 0). Stages 1..STAGES-1 advance if i_stall = 0 and hold if i_stall = 1. Flush wins over stall for stage 0 only.
  2. i_stall = 1: every stage holds.
  3. Otherwise: stage 0 <= {selection, we_in} and stage k <= stage k-1 for k >= 1.
- Latency: an ID instruction appears in stage k after k+1 unstalled edges. o_wb_* reflects it after STAGES edges.
- The WB entry is overwritten every unstalled edge. The block has no handshake and no back-pressure beyond i_stall.
- Hits are combinational from the stage registers and the current i_rs/i_rt:
  - o_rs_hit[k] = we[k] & (dst[k] == i_rs) & (i_rs != 0). o_rt_hit is the same with i_rt.
  - Several bits may be set at once. Priority (youngest stage wins) is resolved by the consumer.
- STAGES = 1: stage 0 is also the WB stage. Flush and stall rules apply unchanged.
- Widths: all compares are BITS_REGS wide unsigned. RA_ADDR is truncated to BITS_REGS.

Test Plan:
- Reset/select:
  - Stimulus: hold i_rst_n = 0 for 2 cycles, then release.
  - Response: all outputs 0.
  - Stimulus: with rt = 7 and rd = 12, drive sel = 00/01/10/11.
  - Response: o_mux_register_rd = 7 / 12 / 31 / 0.
- Pipeline latency:
  - Stimulus: issue rd = 12 with write enabled, then three bubbles.
  - Response: o_dst_flat stage0 = 12 after edge 1, stage1 = 12 after edge 2. o_wb_dst = 12 and o_wb_we = 1 after edge 3, with o_wb_we = 0 after edge 4.
- Register 0 / disabled write:
  - Stimulus: rd = 0 with i_ctl_reg_write = 1, followed by rd = 5 with i_ctl_reg_write = 0, followed by rd = 5 with i_valid = 0.
  - Response: the WB stage shows o_wb_we = 0 for all three. With i_rs = 0, o_rs_hit = 0 always.
- Stall and flush:
  - Stimulus: load destinations 3, 4, 5 into stages 2, 1, 0, then hold i_stall = 1 for 2 cycles.
  - Response: the stages stay at 3, 4, 5.
  - Stimulus: pulse i_stall = 1 together with i_flush = 1.
  - Response: stage 0 becomes bubble while stages 1 and 2 hold 4 and 3.
  - Stimulus: apply i_flush = 1 alone.
  - Response: stage0 = bubble, stage1 = old stage0, stage2 = old stage1.
- Hazard hits:
  - Stimulus: stages hold writing destinations {9, 9, 2}; drive i_rs = 9 and i_rt = 2.
  - Response: o_rs_hit = 3'b011 and o_rt_hit = 3'b100.
  - Stimulus: clear the stage-1 write enable.
  - Response: o_rs_hit = 3'b001.
- Async reset mid-flight:
  - Stimulus: with the pipeline full, pull i_rst_n low between clock edges.
  - Response: all o_we_flat bits, o_dst_flat, o_rs_hit and o_rt_hit drop to 0 immediately, without waiting for an edge.
